pipe_reg_e: RTL

- Decode-to-execute pipeline register of the Y86-64 five-stage pipeline.
- Captures the decode-stage bundle each clock, including d_valA from the forwarding select and d_valB from its twin.
- Generates its own bubble from load/use hazards and mispredicted jumps, and exports the matching stall/bubble requests to the F and D registers.
- Sits between decode/forwarding and the execute ALU/condition-code stage.

---
 rtl/pipe_reg_e.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_reg_e.sv
// Y86-64 decode-to-execute pipeline register with load/use and mispredict bubble control.
// Optional performance counters and bubble export are enabled by defining PIPE_REG_E_PERF_EN.
module pipe_reg_e #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] INOP  = 4'h1,
  parameter logic [2:0] SAOK  = 3'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   D_stat,
  input  logic [3:0]   D_icode,
  input  logic [3:0]   D_ifun,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  input  logic [3:0]   d_srcA,
  input  logic [3:0]   d_srcB,
  input  logic         e_Cnd,
  output logic [2:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [W-1:0] E_valC,
  output logic [W-1:0] E_valA,
  output logic [W-1:0] E_valB,
  output logic [3:0]   E_dstE,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB,
  output logic         load_use,
  output logic         mispredict,
  output logic         F_stall,
  output logic         D_stall,
`ifdef PIPE_REG_E_PERF_EN
  output logic [31:0]  bubble_cnt,
  output logic [31:0]  loaduse_cnt,
  output logic         E_bubble,
`endif
  output logic         D_bubble
);

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] IJXX    = 4'h7;

  typedef struct packed {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valc;
    logic [W-1:0] vala;
    logic [W-1:0] valb;
    logic [3:0]   dste;
    logic [3:0]   dstm;
    logic [3:0]   srca;
    logic [3:0]   srcb;
  } bundle_t;

  localparam bundle_t BUBBLE = '{
    stat: SAOK, icode: INOP, ifun: 4'h0,
    valc: '0, vala: '0, valb: '0,
    dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
  };

  bundle_t e_q;
  bundle_t e_next;
  logic    e_bubble;

  // A load only blocks the consumer when it actually writes a register the consumer reads.
  assign load_use   = ((e_q.icode == IMRMOVQ) || (e_q.icode == IPOPQ)) &&
                      (e_q.dstm != RNONE) &&
                      ((e_q.dstm == d_srcA) || (e_q.dstm == d_srcB));
  assign mispredict = (e_q.icode == IJXX) && !e_Cnd;
  assign e_bubble   = load_use || mispredict;

  assign F_stall  = load_use;
  assign D_stall  = load_use;
  assign D_bubble = mispredict && !load_use;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    e_next = BUBBLE;
    if (!e_bubble) begin
      e_next = '{
        stat: D_stat, icode: D_icode, ifun: D_ifun,
        valc: d_valC, vala: d_valA, valb: d_valB,
        dste: d_dstE, dstm: d_dstM, srca: d_srcA, srcb: d_srcB
      };
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= BUBBLE;
    end else begin
      e_q <= e_next;
    end
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valc;
  assign E_valA  = e_q.vala;
  assign E_valB  = e_q.valb;
  assign E_dstE  = e_q.dste;
  assign E_dstM  = e_q.dstm;
  assign E_srcA  = e_q.srca;
  assign E_srcB  = e_q.srcb;

`ifdef PIPE_REG_E_PERF_EN
  assign E_bubble = e_bubble;

  // Counters saturate rather than wrap so long runs never report a misleadingly small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt  <= '0;
      loaduse_cnt <= '0;
    end else begin
      if (e_bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (load_use && (loaduse_cnt != 32'hFFFF_FFFF)) begin
        loaduse_cnt <= loaduse_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
